// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider scheduler.
//   sched_state_e : scheduler FSM state encoding (3-bit base, 5 states used)
//   ERR_*         : response error codes driven on rsp_error_o
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } sched_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_UNKNOWN = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NUM_REQ requesters.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   en_i    : when low, no grant is produced
//   grant_o : one-hot grant (all zero if nothing valid or disabled)
//   idx_o   : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);
    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        int          s;
        logic [IW-1:0] k;
        s       = 0;
        k       = '0;
        grant_o = '0;
        idx_o   = '0;
        // Scan ptr, ptr+1, ... wrapping at NUM_REQ (not 2**IW), first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            s = int'(ptr_i) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            k = IW'(s);
            if (en_i && (grant_o == '0) && req_i[k]) begin
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// div_sched: shares one iterative divider among NUM_REQ requesters.
// One operation in flight: IDLE (arbitrate) -> LOAD -> ISSUE -> WAIT -> RESP.
// Optional watchdog: define DIV_SCHED_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles with rsp_error_o = ERR_TIMEOUT and zero data.
//   clk_i, rst_i            : clock, async active-high reset
//   req_valid_i/req_ready_o : per-requester handshake (ready is one-hot)
//   req_n_i/req_d_i         : packed operands, requester k at [k*WIDTH +: WIDTH]
//   req_unsigned_i          : 1 unsigned, 0 signed
//   req_out_type_i          : 1 quotient, 0 remainder
//   rsp_*                   : single response channel (valid/ready, id, data, error)
//   div_*_o / div_*_i       : divider control, latched operands and results
module div_sched
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_n_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_d_i,
    input  logic [NUM_REQ-1:0]         req_unsigned_i,
    input  logic [NUM_REQ-1:0]         req_out_type_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [WIDTH-1:0]           rsp_data_o,
    output logic [1:0]                 rsp_error_o,
    output logic                       div_rst_o,
    output logic                       div_valid_o,
    output logic                       div_unsigned_o,
    output logic                       div_out_type_o,
    output logic [WIDTH-1:0]           div_n_o,
    output logic [WIDTH-1:0]           div_d_o,
    input  logic                       div_ready_i,
    input  logic [WIDTH-1:0]           div_q_i,
    input  logic [WIDTH-1:0]           div_r_i,
    input  logic [1:0]                 div_error_i
);
    localparam int IW = $clog2(NUM_REQ);

    sched_state_e     state_q;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    id_q;
    logic [WIDTH-1:0] n_q, d_q, rsp_data_q;
    logic             uns_q, ot_q;
    logic             rsp_valid_q, div_rst_q, div_valid_q;
    logic [1:0]       rsp_err_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic [WIDTH-1:0]   sel_n, sel_d;

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q;
`endif

    // Grants only in IDLE; masked during reset so req_ready_o reads 0.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    ((state_q == S_IDLE) && !rst_i),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    assign ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);

    always_comb begin
        sel_n = '0;
        sel_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IW'(k)) begin
                sel_n = req_n_i[k*WIDTH +: WIDTH];
                sel_d = req_d_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            n_q         <= '0;
            d_q         <= '0;
            uns_q       <= 1'b0;
            ot_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_NONE;
            div_rst_q   <= 1'b0;
            div_valid_q <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            // Strobes are single-cycle by construction.
            div_rst_q   <= 1'b0;
            div_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_grant != '0) begin
                        id_q      <= arb_idx;
                        n_q       <= sel_n;
                        d_q       <= sel_d;
                        uns_q     <= req_unsigned_i[arb_idx];
                        ot_q      <= req_out_type_i[arb_idx];
                        ptr_q     <= ptr_d;
                        div_rst_q <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    div_valid_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: begin
`ifdef DIV_SCHED_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Only WAIT samples div_ready_i, so a stale done left
                    // over from the previous op during LOAD/ISSUE is ignored.
                    if (div_ready_i) begin
                        rsp_data_q  <= ot_q ? div_q_i : div_r_i;
                        rsp_err_q   <= div_error_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
`ifdef DIV_SCHED_TIMEOUT_EN
                    // Fires after TIMEOUT_CYCLES cycles spent in WAIT.
                    else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = arb_grant;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_id_o       = id_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_error_o    = rsp_err_q;
    assign div_rst_o      = div_rst_q;
    assign div_valid_o    = div_valid_q;
    assign div_unsigned_o = uns_q;
    assign div_out_type_o = ot_q;
    assign div_n_o        = n_q;
    assign div_d_o        = d_q;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: self-checking bench for div_sched with a behavioural divider
// model and a round-robin reference model.
module tb_div_sched;
    localparam int W    = 32;
    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int TO_C = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   e;
    } dres_t;

    typedef struct {
        int           id;
        logic [W-1:0] n, d;
        bit           uns, oq;
        int           lat, stall;
        logic [W-1:0] xd;
        logic [1:0]   xe;
    } vec_t;

    logic clk, rst;
    logic [N-1:0]   vld, rdy_o, fu, fo;
    logic [N*W-1:0] req_n, req_d;
    logic [W-1:0]   fn [N];
    logic [W-1:0]   fd [N];
    logic           rsp_ready, rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_err;
    logic           div_rst, div_valid, div_uns, div_ot;
    logic [W-1:0]   div_n, div_d;
    logic           dv_rdy;
    dres_t          dv;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int last_w = -1;
    int div_lat = 0;
    int done_at = 0;
    bit busy = 0;

    div_sched #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO_C)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vld), .req_ready_o(rdy_o),
        .req_n_i(req_n), .req_d_i(req_d),
        .req_unsigned_i(fu), .req_out_type_i(fo),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_error_o(rsp_err),
        .div_rst_o(div_rst), .div_valid_o(div_valid),
        .div_unsigned_o(div_uns), .div_out_type_o(div_ot),
        .div_n_o(div_n), .div_d_o(div_d),
        .div_ready_i(dv_rdy), .div_q_i(dv.q), .div_r_i(dv.r), .div_error_i(dv.e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_n = '0;
        req_d = '0;
        for (int k = 0; k < N; k++) begin
            req_n[k*W +: W] = fn[k];
            req_d[k*W +: W] = fd[k];
        end
    end

    // Reference divide; x/0 gives all-ones quotient, remainder = n, error 01.
    function automatic dres_t ref_div(input logic [W-1:0] n, input logic [W-1:0] d, input logic uns);
        logic signed [W-1:0] sn, sd;
        dres_t res;
        sn = n;
        sd = d;
        res.e = 2'b00;
        if (d == '0) begin
            res.q = '1; res.r = n; res.e = 2'b01;
        end else if (uns) begin
            res.q = n / d; res.r = n % d;
        end else if (n == 32'h8000_0000 && d == '1) begin
            res.q = n; res.r = '0;
        end else begin
            res.q = sn / sd; res.r = sn % sd;
        end
        return res;
    endfunction

    // Divider model: started by div_valid_o, ready div_lat+1 cycles after
    // ISSUE; done stays high (stale) until the next start.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            dv_rdy <= 1'b0;
            busy   <= 1'b0;
            dv     <= '0;
        end else if (div_valid) begin
            busy    <= 1'b1;
            dv_rdy  <= 1'b0;
            done_at <= cyc + div_lat + 1;
        end else if (busy && cyc == done_at) begin
            busy   <= 1'b0;
            dv_rdy <= 1'b1;
            dv     <= ref_div(div_n, div_d, div_uns);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_req_ready"}, rdy_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_div_rst"}, div_rst, 0);
        chk({tag, "_div_valid"}, div_valid, 0);
        chk({tag, "_div_mode"}, {div_uns, div_ot}, 0);
        chk({tag, "_div_n"}, div_n, 0);
        chk({tag, "_div_d"}, div_d, 0);
    endtask

    // Round-robin rule: first valid requester after the last one served.
    function automatic int exp_winner(input logic [N-1:0] m);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last_w + i + N) % N;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    // One full transaction; entered and left at negedge inside an IDLE cycle.
    task automatic do_op(input int lat, input int stall, input bit to,
                         output logic [IW-1:0] got_id, output logic [W-1:0] got_d,
                         output logic [1:0] got_e);
        int w, a, t;
        dres_t e;
        logic [W-1:0] ed, hd;
        logic [1:0] ee, he;
        logic [IW-1:0] hid;
        logic [N-1:0] oh;
        bit leak, moved;
        w = exp_winner(vld);
        div_lat = lat;
        #1;
        t = 0;
        while (rdy_o == '0 && t < 20) begin @(negedge clk); #1; t++; end
        oh = '0;
        oh[w] = 1'b1;
        chk("grant", rdy_o, oh);
        a = cyc;
        e = ref_div(fn[w], fd[w], fu[w]);
        ed = to ? '0 : (fo[w] ? e.q : e.r);
        ee = to ? 2'b10 : e.e;
        last_w = w;
        @(negedge clk);
        vld[w] = 1'b0;
        #1;
        leak = 0;
        t = 0;
        while (!rsp_valid && t < 2000) begin
            leak |= (rdy_o != '0);
            @(negedge clk); #1; t++;
        end
        chk("latency", cyc - a, to ? 3 + TO_C : 4 + lat);
        chk("rsp_id", rsp_id, w);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, ee);
        got_id = rsp_id; got_d = rsp_data; got_e = rsp_err;
        hd = rsp_data; he = rsp_err; hid = rsp_id;
        moved = 0;
        repeat (stall) begin
            @(negedge clk); #1;
            moved |= (!rsp_valid || rsp_data !== hd || rsp_err !== he || rsp_id !== hid);
            leak  |= (rdy_o != '0);
        end
        chk("rsp_hold", moved, 0);
        chk("no_grant_busy", leak, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    vec_t tbl [9];
    int   fair_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [IW-1:0] gid;
        logic [W-1:0]  gd;
        logic [1:0]    ge;
        int t;
        tbl[0] = '{2, 32'd100, 32'd7, 1'b1, 1'b1, 5, 0, 32'd14, 2'b00};
        tbl[1] = '{2, 32'd100, 32'd7, 1'b1, 1'b0, 5, 0, 32'd2, 2'b00};
        tbl[2] = '{1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1, 3, 0, 32'hFFFF_FFF2, 2'b00};
        tbl[3] = '{1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 2, 0, 32'hFFFF_FFFE, 2'b00};
        tbl[4] = '{3, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 0, 0, 32'h2492_4916, 2'b00};
        tbl[5] = '{0, 32'd5, 32'd0, 1'b1, 1'b1, 1, 0, 32'hFFFF_FFFF, 2'b01};
        tbl[6] = '{0, 32'd5, 32'd0, 1'b1, 1'b0, 1, 0, 32'd5, 2'b01};
        tbl[7] = '{3, 32'd1000, 32'd33, 1'b1, 1'b1, 4, 10, 32'd30, 2'b00};
        tbl[8] = '{2, 32'd1000, 32'd33, 1'b1, 1'b0, 0, 3, 32'd10, 2'b00};

        rst = 1'b1; vld = '0; rsp_ready = 1'b0; fu = '0; fo = '0;
        for (int k = 0; k < N; k++) begin fn[k] = '0; fd[k] = '0; end
        repeat (2) @(negedge clk);
        #1;
        chk_rst("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fairness: every requester re-requests as soon as it is served.
        for (int k = 0; k < N; k++) begin
            fn[k] = 32'(100 + 10 * k); fd[k] = 32'd7; fu[k] = 1'b1; fo[k] = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            vld = '1;
            do_op(i % 3, 0, 0, gid, gd, ge);
            chk("fair_order", gid, fair_exp[i]);
        end

        // Directed vectors, one requester at a time.
        for (int i = 0; i < 9; i++) begin
            vld = '0;
            fn[tbl[i].id] = tbl[i].n; fd[tbl[i].id] = tbl[i].d;
            fu[tbl[i].id] = tbl[i].uns; fo[tbl[i].id] = tbl[i].oq;
            vld[tbl[i].id] = 1'b1;
            do_op(tbl[i].lat, tbl[i].stall, 0, gid, gd, ge);
            chk("vec_id", gid, tbl[i].id);
            chk("vec_data", gd, tbl[i].xd);
            chk("vec_err", ge, tbl[i].xe);
        end

        // Reset pulsed while the scheduler sits in WAIT.
        vld = '0; fn[3] = 32'd77; fd[3] = 32'd5; vld[3] = 1'b1; div_lat = 50;
        #1;
        t = 0;
        while (rdy_o == '0 && t < 20) begin @(negedge clk); #1; t++; end
        chk("midrst_grant", rdy_o, 4'b1000);
        @(negedge clk);
        vld = '0;
        repeat (5) @(negedge clk);
        #1;
        chk("midrst_busy", {rsp_valid, rsp_id}, 3'b011);
        rst = 1'b1;
        #1;
        chk_rst("midrst");
        @(negedge clk);
        rst = 1'b0;
        last_w = -1;
        vld = '1;
        fn[0] = 32'd81; fd[0] = 32'd9; fu[0] = 1'b1; fo[0] = 1'b1;
        do_op(2, 1, 0, gid, gd, ge);
        chk("post_rst_id", gid, 0);
        chk("post_rst_data", gd, 9);

        // Randomized traffic against the reference models.
        for (int k = 0; k < N; k++) begin
            fn[k] = $urandom; fd[k] = $urandom_range(1, 1000);
            fu[k] = 1'($urandom_range(0, 1)); fo[k] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 40; i++) begin
            vld = N'($urandom_range(1, (1 << N) - 1));
            do_op($urandom_range(0, 6), $urandom_range(0, 3), 0, gid, gd, ge);
            fn[last_w] = $urandom;
            fd[last_w] = ($urandom_range(0, 7) == 0) ? '0 :
                         ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 100));
            fu[last_w] = 1'($urandom_range(0, 1));
            fo[last_w] = 1'($urandom_range(0, 1));
        end

`ifdef DIV_SCHED_TIMEOUT_EN
        // Divider never finishes: watchdog must produce the response.
        vld = '0; fn[1] = 32'd50; fd[1] = 32'd5; vld[1] = 1'b1;
        do_op(5000, 2, 1, gid, gd, ge);
        chk("timeout_err", ge, 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one iterative divider instance among `NUM_REQ` requesters (e.g. pipeline lanes or a CSR-side test port). It accepts one operation at a time and sequences the divider through load, start and completion. It returns the selected result (quotient or remainder) with the requester ID on a single response channel. It sits between the execute stage's divide requesters and the divider core.

## Interface
- `WIDTH`, 32, operand/result width
- `NUM_REQ`, 4, number of requesters (2..16)
- `TIMEOUT_CYCLES`, 256, divider watchdog limit (used only with the timeout feature)
- `clk_i` in 1: posedge clock
- `rst_i` in 1: reset, asynchronous, active-high
- `req_valid_i` in NUM_REQ: per-requester request valid
- `req_ready_o` out NUM_REQ: one-hot grant/accept
- `req_n_i` in NUM_REQ*WIDTH: numerators, requester k at bits [k*WIDTH +: WIDTH]
- `req_d_i` in NUM_REQ*WIDTH: denominators, same packing
- `req_unsigned_i` in NUM_REQ: 1 unsigned, 0 signed
- `req_out_type_i` in NUM_REQ: 1 quotient, 0 remainder
- `rsp_valid_o` out 1: response valid
- `rsp_ready_i` in 1: response consumer ready
- `rsp_id_o` out $clog2(NUM_REQ): ID of the requester that owns the response
- `rsp_data_o` out WIDTH: selected result
- `rsp_error_o` out 2: divider error code, or 2'b10 on timeout
- `div_rst_o` out 1: divider restart/operand-load strobe
- `div_valid_o` out 1: divider start
- `div_unsigned_o`, `div_out_type_o` out 1 each: latched mode bits
- `div_n_o`, `div_d_o` out WIDTH: latched operands, held stable from LOAD through WAIT
- `div_ready_i` in 1: divider done
- `div_q_i`, `div_r_i` in WIDTH: divider quotient and remainder
- `div_error_i` in 2: divider error code

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT, RESP.
- **IDLE:**
  - Arbitrate among `req_valid_i` round-robin, starting at `rr_ptr`.
  - If any request is valid, assert `req_ready_o` one-hot for the winner in the same cycle (combinational).
  - Latch the winner's operands, mode, out_type and ID. Set `rr_ptr` to winner+1 mod NUM_REQ. Go to LOAD.
  - `req_ready_o` is 0 in every other state.
- **LOAD:** `div_rst_o`=1 for exactly one cycle with operands driven. Go to ISSUE.
- **ISSUE:** `div_valid_o`=1 for exactly one cycle. Clear the watchdog. Go to WAIT.
- **WAIT:**
  - Hold operands until `div_ready_i`=1.
  - On that cycle, capture `rsp_data` = out_type ? `div_q_i` : `div_r_i`, and capture `rsp_error` = `div_error_i`.
  - Go to RESP.
- **RESP:**
  - `rsp_valid_o`=1. Data, ID and error are held stable until `rsp_ready_i`=1; then go to IDLE.
  - The next arbitration happens no earlier than the IDLE cycle after the handshake; there is no overlap.
- Requesters must hold request fields stable while valid and unaccepted. A requester that drops valid before its grant simply loses its turn.
- Divide-by-zero is not special-cased: the divider's result and error code are passed through unchanged.
- Unused state encodings go to IDLE with all outputs inactive.

## Timing
- Reset values: `req_ready_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_data_o`=0, `rsp_error_o`=0, `div_rst_o`=0, `div_valid_o`=0, divider operand/mode outputs=0, `rr_ptr`=0, state=IDLE.
- Cycle map:
  - Cycle 0: accept handshake.
  - Cycle 1: LOAD.
  - Cycle 2: ISSUE.
  - Cycle 3 onward: WAIT.
  - If `div_ready_i` is first seen high at cycle k (k≥3), `rsp_valid_o` rises at k+1.
- Minimum accept-to-response latency: 4 cycles.
- Throughput: one operation per (divider latency + 4 + response stall) cycles.
- A `div_ready_i` that is already high during LOAD or ISSUE (stale done from the previous op) is ignored; only WAIT samples it.
- Reset asserted mid-operation aborts immediately (asynchronous). `div_rst_o` is 0 while `rst_i` is high; the divider is re-initialised by the next LOAD.

## Configuration
- `DIV_SCHED_TIMEOUT_EN` defined:
  - A watchdog counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT.
  - When it reaches `TIMEOUT_CYCLES` without `div_ready_i`, go to RESP with `rsp_data_o`=0 and `rsp_error_o`=2'b10.
  - The divider is restarted by the next LOAD.
- `DIV_SCHED_TIMEOUT_EN` undefined: no counter is generated; WAIT waits indefinitely and `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `div_pkg`:
  - FSM state enum for the scheduler, with an explicit base type wide enough for its five states.
  - Error code localparams: ERR_NONE=2'b00, ERR_TIMEOUT=2'b10, ERR_UNKNOWN=2'b11.
- One sub-module, `rr_arbiter`: parameterised `NUM_REQ`. Inputs are the request vector, `rr_ptr` and an enable; output is a one-hot grant plus the binary winner index. Purely combinational; the pointer register lives in `div_sched`.

## Test plan
- **Single unsigned request:** requester 2 sends n=100, d=7, out_type=1; divider model (5-cycle latency) returns q=14, r=2 → `rsp_valid_o` with `rsp_id_o`=2, `rsp_data_o`=14, `rsp_error_o`=0; response 4+5 cycles after accept.
- **Remainder select:** same operands with out_type=0 → `rsp_data_o`=2.
- **Fairness:** all 4 requesters held valid from reset → grants in order 0,1,2,3,0; no requester is granted twice before the others are served.
- **Backpressure:** `rsp_ready_i` held 0 for 10 cycles after `rsp_valid_o` → data, ID and error stable; no new `req_ready_o` until the handshake completes.
- **Mid-op reset:** `rst_i` pulsed during WAIT → all outputs return to their reset values asynchronously; the next request is granted to requester 0 and completes normally.
- **Timeout:** with `DIV_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16 and `div_ready_i` never asserted → `rsp_valid_o` at ISSUE+17, `rsp_error_o`=2'b10, `rsp_data_o`=0.
